sipo_deserializer: RTL and testbench
====================================

// Module: sipo_deserializer
// PURPOSE
//   Serial-in, parallel-out receiver: the far end of the team's LSB-first PISO serialiser link.
//   Collects DATA_WIDTH serial bits, LSB first, into a word and presents it on a valid/ready output.
//   Sits between a 1-bit serial lane and a parallel consumer that may stall.
// PARAMETERS
//   DATA_WIDTH  16  bits per word; legal range >= 2
// PORTS
//   clk          in   1           single clock, all logic on rising edge
//   reset        in   1           synchronous, active-high reset
//   din          in   1           serial data bit
//   din_valid    in   1           din carries a valid bit this cycle
//   frame_start  in   1           resynchronise: discard any partial word
//   dout         out  DATA_WIDTH  assembled word (din bit k -> dout[k])
//   dout_valid   out  1           dout holds an unconsumed word
//   dout_ready   in   1           consumer accepts dout when dout_valid=1
//   overflow     out  1           one-cycle pulse: completed word dropped
// BEHAVIOUR
//   - Reset (reset=1 at posedge): shift reg=0, bit_cnt=0, dout=0, dout_valid=0, overflow=0.
//     Reset takes priority over every other input; a partial word is lost.
//   - Bit accept: din_valid=1 -> shift reg <= {din, shreg[W-1:1]}; bit_cnt+1. din_valid=0 -> hold.
//   - bit_cnt: width $clog2(DATA_WIDTH); counts 0..W-1; wraps to 0 on the W-th accepted bit.
//   - Word complete: W-th bit accepted in cycle N -> word {din, shreg[W-1:1]} offered to the
//     output register at posedge N; dout/dout_valid update in cycle N+1 (1-cycle latency).
//   - frame_start=1, din_valid=0: partial word discarded, bit_cnt<=0.
//   - frame_start=1, din_valid=1: partial word discarded; din becomes bit 0; bit_cnt<=1.
//   - frame_start never affects the output register (a held word stays valid).
//   - Output handshake: transfer when dout_valid & dout_ready. dout is stable while
//     dout_valid=1 & dout_ready=0. dout keeps its last value after consumption.
//   - Completion with output empty or consumed same cycle (dout_valid=0 or dout_ready=1):
//     load new word, dout_valid<=1, no overflow (back-to-back words sustain full rate).
//   - Completion while dout_valid=1 & dout_ready=0: new word dropped, old word kept,
//     overflow=1 for exactly the next cycle; assembly continues at bit_cnt=0.
//   - Consumption with no completion: dout_valid<=0.
//   - DATA_WIDTH=2^k: counter wraps naturally; otherwise compare against W-1 explicitly.
// STRUCTURE
//   - sipo_pkg: function/localparam for counter width (clog2), shared with the PISO side.
//   - One sub-module: sipo_out_reg (1-entry valid/ready holding register with drop/overflow).
//   - Top holds shift register, bit counter, frame_start handling.
// TESTING (W=8 unless noted)
//   - Reset: reset=1 two cycles mid-word -> dout=0x00, dout_valid=0, overflow=0; next
//     8 bits form a fresh word.
//   - Basic: dout_ready=1, bits 1,0,1,0,0,1,0,1 on consecutive cycles -> dout=0xA5,
//     dout_valid=1 for one cycle, one cycle after the 8th bit.
//   - Gaps + restart: 3 bits, din_valid=0 for 4 cycles, frame_start=1 with din=1, then 7 bits
//     0 -> dout=0x01; first 3 bits not present.
//   - Stall/overflow: dout_ready=0, send 0x3C then 0xC3 -> dout stays 0x3C, overflow pulses
//     one cycle after 0xC3's last bit; then dout_ready=1 -> 0x3C consumed, dout_valid=0.
//   - Back-to-back: dout_ready=1, 0x12 then 0x34 with no gaps -> dout_valid high 2
//     non-adjacent single cycles, values 0x12 then 0x34, no overflow;
//     repeat with W=16 and W=12 to cover non-power-of-2 wrap.

Source files
------------

// File: rtl/sipo_pkg.sv
// Shared definitions for the LSB-first serial link (PISO transmitter and SIPO receiver).
package sipo_pkg;

  localparam int DEFAULT_DATA_WIDTH = 16;

  // Bit counter width for a given word width; never narrower than one bit.
  function automatic int cntWidth(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/sipo_out_reg.sv
// One-entry valid/ready holding register; drops incoming words while a stalled word is held.
module sipo_out_reg #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  load_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  ready_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o,
  output logic                  overflow_o
);

  logic [DATA_WIDTH-1:0] data_q;
  logic                  valid_q;
  logic                  overflow_q;

  // A new word may enter when the slot is empty or being drained this same cycle.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      data_q     <= '0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= 1'b0;
      if (load_i) begin
        if (!valid_q || ready_i) begin
          data_q  <= data_i;
          valid_q <= 1'b1;
        end else begin
          overflow_q <= 1'b1;
        end
      end else if (valid_q && ready_i) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign data_o     = data_q;
  assign valid_o    = valid_q;
  assign overflow_o = overflow_q;

endmodule

// File: rtl/sipo_deserializer.sv
// Serial-in, parallel-out receiver: assembles LSB-first bits into words for a stallable consumer.
module sipo_deserializer
  import sipo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  din,
  input  logic                  din_valid,
  input  logic                  frame_start,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic                  overflow
);

  localparam int               CNT_W    = cntWidth(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  // Only the upper W-1 bits are stored: the lowest bit of the shifter would be
  // shifted out on the same edge the word completes, so it is never needed.
  logic [DATA_WIDTH-2:0] shiftReg_q, shiftReg_d;
  logic [CNT_W-1:0]      bitCnt_q, bitCnt_d;
  logic [DATA_WIDTH-1:0] nextWord;
  logic                  wordDone;

  assign nextWord = {din, shiftReg_q};

  always_comb begin
    shiftReg_d = shiftReg_q;
    bitCnt_d   = bitCnt_q;
    wordDone   = 1'b0;
    if (frame_start) begin
      shiftReg_d = '0;
      if (din_valid) begin
        shiftReg_d[DATA_WIDTH-2] = din;
        bitCnt_d                 = CNT_W'(1);
      end else begin
        bitCnt_d = '0;
      end
    end else if (din_valid) begin
      shiftReg_d = nextWord[DATA_WIDTH-1:1];
      if (bitCnt_q == LAST_BIT) begin
        bitCnt_d = '0;
        wordDone = 1'b1;
      end else begin
        bitCnt_d = bitCnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shiftReg_q <= '0;
      bitCnt_q   <= '0;
    end else begin
      shiftReg_q <= shiftReg_d;
      bitCnt_q   <= bitCnt_d;
    end
  end

  sipo_out_reg #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_outReg (
    .clk_i      (clk),
    .reset_i    (reset),
    .load_i     (wordDone),
    .data_i     (nextWord),
    .ready_i    (dout_ready),
    .data_o     (dout),
    .valid_o    (dout_valid),
    .overflow_o (overflow)
  );

endmodule

// File: tb/tb_sipo_deserializer.sv
// Directed bench for sipo_deserializer at widths 8, 16 and 12 sharing one input stream.
module tb_sipo_deserializer;

  logic        clk;
  logic        reset;
  logic        din;
  logic        dinValid;
  logic        frameStart;
  logic        doutReady;
  logic [7:0]  dout8;
  logic [15:0] dout16;
  logic [11:0] dout12;
  logic        valid8, valid16, valid12;
  logic        ovf8, ovf16, ovf12;

  int testsRun    = 0;
  int testsFailed = 0;

  sipo_deserializer #(.DATA_WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .din(din), .din_valid(dinValid), .frame_start(frameStart),
    .dout(dout8), .dout_valid(valid8), .dout_ready(doutReady), .overflow(ovf8)
  );

  sipo_deserializer #(.DATA_WIDTH(16)) dut16 (
    .clk(clk), .reset(reset), .din(din), .din_valid(dinValid), .frame_start(frameStart),
    .dout(dout16), .dout_valid(valid16), .dout_ready(doutReady), .overflow(ovf16)
  );

  sipo_deserializer #(.DATA_WIDTH(12)) dut12 (
    .clk(clk), .reset(reset), .din(din), .din_valid(dinValid), .frame_start(frameStart),
    .dout(dout12), .dout_valid(valid12), .dout_ready(doutReady), .overflow(ovf12)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every comparison funnels through here so the counters stay honest.
  task automatic checkOutput(input string tag, input logic [15:0] actual, input logic [15:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Drive one cycle of inputs, then return 1ns after the edge that consumed them.
  task automatic applyStimulus(input logic v, input logic b, input logic fs);
    dinValid   = v;
    din        = b;
    frameStart = fs;
    @(posedge clk);
    #1;
  endtask

  task automatic sendRange(input logic [15:0] w, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) applyStimulus(1'b1, w[i], 1'b0);
  endtask

  task automatic sampleOut(input int w, output logic [15:0] d, output logic v, output logic o);
    case (w)
      16:      begin d = dout16;          v = valid16; o = ovf16; end
      12:      begin d = {4'h0, dout12};  v = valid12; o = ovf12; end
      default: begin d = {8'h00, dout8};  v = valid8;  o = ovf8;  end
    endcase
  endtask

  task automatic backToBack(input int w, input logic [15:0] a, input logic [15:0] b);
    logic [15:0] d;
    logic        v, o;
    doutReady = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b1);
    sendRange(a, 0, w - 1);
    sampleOut(w, d, v, o);
    checkOutput($sformatf("b2b%0d_first_data", w), d, a);
    checkOutput($sformatf("b2b%0d_first_valid", w), {15'h0, v}, 16'h1);
    checkOutput($sformatf("b2b%0d_first_ovf", w), {15'h0, o}, 16'h0);
    applyStimulus(1'b1, b[0], 1'b0);
    sampleOut(w, d, v, o);
    checkOutput($sformatf("b2b%0d_gap_valid", w), {15'h0, v}, 16'h0);
    sendRange(b, 1, w - 1);
    sampleOut(w, d, v, o);
    checkOutput($sformatf("b2b%0d_second_data", w), d, b);
    checkOutput($sformatf("b2b%0d_second_valid", w), {15'h0, v}, 16'h1);
    checkOutput($sformatf("b2b%0d_second_ovf", w), {15'h0, o}, 16'h0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    sampleOut(w, d, v, o);
    checkOutput($sformatf("b2b%0d_drained", w), {15'h0, v}, 16'h0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    din        = 1'b0;
    dinValid   = 1'b0;
    frameStart = 1'b0;
    doutReady  = 1'b1;
    reset      = 1'b1;

    // Power-on reset
    repeat (2) applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("por_dout", {8'h00, dout8}, 16'h0000);
    checkOutput("por_valid", {15'h0, valid8}, 16'h0);
    checkOutput("por_ovf", {15'h0, ovf8}, 16'h0);
    reset = 1'b0;

    // Reset mid-word, with valid bits still arriving to prove reset wins
    sendRange(16'h0007, 0, 2);
    reset = 1'b1;
    repeat (2) applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("rst_mid_dout", {8'h00, dout8}, 16'h0000);
    checkOutput("rst_mid_valid", {15'h0, valid8}, 16'h0);
    checkOutput("rst_mid_ovf", {15'h0, ovf8}, 16'h0);
    reset = 1'b0;
    sendRange(16'h005A, 0, 6);
    checkOutput("rst_fresh_early_valid", {15'h0, valid8}, 16'h0);
    checkOutput("rst_fresh_early_dout", {8'h00, dout8}, 16'h0000);
    sendRange(16'h005A, 7, 7);
    checkOutput("rst_fresh_dout", {8'h00, dout8}, 16'h005A);
    checkOutput("rst_fresh_valid", {15'h0, valid8}, 16'h1);

    // Basic word 0xA5
    sendRange(16'h00A5, 0, 6);
    checkOutput("basic_before_valid", {15'h0, valid8}, 16'h0);
    sendRange(16'h00A5, 7, 7);
    checkOutput("basic_dout", {8'h00, dout8}, 16'h00A5);
    checkOutput("basic_valid", {15'h0, valid8}, 16'h1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("basic_one_cycle", {15'h0, valid8}, 16'h0);
    checkOutput("basic_dout_kept", {8'h00, dout8}, 16'h00A5);

    // Gaps, then frame_start carrying bit 0
    sendRange(16'h0007, 0, 2);
    repeat (4) applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1);
    sendRange(16'h0000, 0, 3);
    checkOutput("restart_early_valid", {15'h0, valid8}, 16'h0);
    checkOutput("restart_early_dout", {8'h00, dout8}, 16'h00A5);
    sendRange(16'h0000, 0, 2);
    checkOutput("restart_dout", {8'h00, dout8}, 16'h0001);
    checkOutput("restart_valid", {15'h0, valid8}, 16'h1);

    // frame_start without a bit: counter restarts at zero
    sendRange(16'h0003, 0, 1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    sendRange(16'h00F0, 0, 5);
    checkOutput("fs_idle_early_valid", {15'h0, valid8}, 16'h0);
    checkOutput("fs_idle_early_dout", {8'h00, dout8}, 16'h0001);
    sendRange(16'h00F0, 6, 7);
    checkOutput("fs_idle_dout", {8'h00, dout8}, 16'h00F0);
    applyStimulus(1'b0, 1'b0, 1'b0);

    // Stall: second word dropped with a single-cycle overflow pulse
    doutReady = 1'b0;
    sendRange(16'h003C, 0, 7);
    checkOutput("stall_first_dout", {8'h00, dout8}, 16'h003C);
    checkOutput("stall_first_valid", {15'h0, valid8}, 16'h1);
    checkOutput("stall_first_ovf", {15'h0, ovf8}, 16'h0);
    sendRange(16'h00C3, 0, 6);
    checkOutput("stall_pre_ovf", {15'h0, ovf8}, 16'h0);
    sendRange(16'h00C3, 7, 7);
    checkOutput("stall_ovf", {15'h0, ovf8}, 16'h1);
    checkOutput("stall_held_dout", {8'h00, dout8}, 16'h003C);
    checkOutput("stall_held_valid", {15'h0, valid8}, 16'h1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("stall_ovf_pulse", {15'h0, ovf8}, 16'h0);
    checkOutput("stall_still_dout", {8'h00, dout8}, 16'h003C);
    doutReady = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("stall_consumed_valid", {15'h0, valid8}, 16'h0);
    checkOutput("stall_consumed_dout", {8'h00, dout8}, 16'h003C);

    // Completion on the same cycle the held word is consumed
    doutReady = 1'b0;
    sendRange(16'h0011, 0, 7);
    sendRange(16'h0022, 0, 6);
    doutReady = 1'b1;
    sendRange(16'h0022, 7, 7);
    checkOutput("swap_dout", {8'h00, dout8}, 16'h0022);
    checkOutput("swap_valid", {15'h0, valid8}, 16'h1);
    checkOutput("swap_ovf", {15'h0, ovf8}, 16'h0);
    applyStimulus(1'b0, 1'b0, 1'b0);

    // frame_start leaves a held word alone
    doutReady = 1'b0;
    sendRange(16'h0077, 0, 7);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("fs_hold_valid", {15'h0, valid8}, 16'h1);
    checkOutput("fs_hold_dout", {8'h00, dout8}, 16'h0077);
    doutReady = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0);

    // Back-to-back at full rate, including non-power-of-2 width
    backToBack(8, 16'h0012, 16'h0034);
    backToBack(16, 16'hBEEF, 16'h1234);
    backToBack(12, 16'h0ABC, 16'h05D3);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
